ctrl_fsm: RTL and testbench
===========================

Name: ctrl_fsm

Overview:
Multi-cycle sequencer for the RV32I core. It consumes the instruction-decode fields (opcode, invalid, funct3) and the branch compare result, and drives the load-enables and mux selects for the PC, IR, register file, ALU operands and memory bus. It sits between the decoder and the datapath, and owns the single shared memory port used for both instruction fetch and load/store.

Parameters:
MAX_WAIT, 0, maximum cycles to wait on mem_ready per request; 0 = wait forever; otherwise exceeding it enters TRAP.
WAIT_W, 8, width of the wait counter; MAX_WAIT must be < 2**WAIT_W.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
opcode  in  5  insn[6:2] from decoder (IR-registered)
invalid  in  1  decoder invalid flag (insn[1:0] != 2'b11)
br_taken  in  1  branch comparator result, valid in EXEC
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request valid
mem_we  out  1  store when 1, read when 0
addr_sel  out  1  0 = PC (fetch), 1 = ALU result (load/store)
ir_we  out  1  latch fetched word into IR
pc_we  out  1  update PC
pc_sel  out  2  0 = PC+4, 1 = branch/JAL target, 2 = JALR target (ALU, bit0 cleared)
alu_a_sel  out  1  0 = rs1, 1 = PC
alu_b_sel  out  1  0 = rs2, 1 = immediate
rf_we  out  1  register-file write (x0 writes are dropped by the regfile)
wb_sel  out  2  0 = ALU, 1 = memory data, 2 = PC+4, 3 = immediate (LUI)
trap  out  1  sticky fault indication
state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. All outputs are Moore-decoded from state and opcode. Opcode is stable from DECODE onward because the IR holds it.
- Reset (async): state=FETCH, wait counter=0. With rst high all outputs are 0 except state=0; mem_req rises the first cycle after rst falls. Reset mid-request abandons the request with no PC/IR/RF update.
- FETCH: mem_req=1, mem_we=0, addr_sel=0. On mem_ready, ir_we=1 and go to DECODE; otherwise stay.
- DECODE: if invalid, or opcode is not in {LOAD 00000, MISC-MEM 00011, OP-IMM 00100, AUIPC 00101, STORE 01000, OP 01100, LUI 01101, BRANCH 11000, JALR 11001, JAL 11011}, go to TRAP. Otherwise go to EXEC. SYSTEM (11100) goes to TRAP.
- EXEC:
  - OP: a=rs1, b=rs2.
  - OP-IMM, LOAD, STORE, JALR: a=rs1, b=imm.
  - AUIPC, JAL: a=PC, b=imm.
  - Transitions: LOAD/STORE go to MEM. BRANCH asserts pc_we with pc_sel = br_taken ? 1 : 0, then goes to FETCH. MISC-MEM (fence = nop) asserts pc_we with pc_sel=0, then goes to FETCH. All others go to WB.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE. On mem_ready: LOAD goes to WB; STORE asserts pc_we with pc_sel=0 and goes to FETCH. Otherwise stay.
- WB: rf_we=1 and pc_we=1.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, else 0.
  - pc_sel: JAL=1, JALR=2, else 0.
  - Then go to FETCH.
- TRAP: trap=1 and all enables 0. Sticky until rst.
- Wait counter: cleared on entry to FETCH/MEM and on mem_ready; increments each cycle mem_req=1 and mem_ready=0. If MAX_WAIT != 0 and the counter reaches MAX_WAIT with mem_ready still low, go to TRAP next cycle; mem_ready in the same cycle wins.
- Latency, zero-wait memory: ALU/LUI/AUIPC/JAL/JALR = 4 cycles; BRANCH/fence = 3; LOAD = 5; STORE = 4.
- mem_ready outside FETCH/MEM is ignored.

Optional Feature:
CTRL_INSTRET_EN:
- Defined: adds output instret[63:0], reset to 0, incremented by 1 each cycle pc_we=1 (one per retired instruction), wrapping at 2**64.
- Undefined: port and counter absent; no other change.

Decomposition:
- Package ctrl_pkg: state encodings, the 5-bit opcode constants, pc_sel and wb_sel encodings. These are shared with decode and datapath.
- Sub-module ctrl_wait_cnt: the mem_ready timeout counter with parameters MAX_WAIT and WAIT_W, outputs timeout. All other logic stays in one module.

Test Plan:
1. Reset asserted mid-FETCH with mem_req=1 -> state=0, all enables 0 asynchronously; mem_req=1 the cycle after release.
2. OP (opcode 01100) with mem_ready always 1 -> ir_we at cycle 1, rf_we=1 with wb_sel=0 and pc_we=1 with pc_sel=0 at cycle 4, back in FETCH at cycle 5.
3. BRANCH with br_taken=1 -> pc_we=1 and pc_sel=1 in EXEC, rf_we never 1; with br_taken=0 -> pc_sel=0.
4. LOAD with mem_ready low for 3 cycles in MEM -> stays in MEM, mem_we=0, addr_sel=1; then WB with wb_sel=1; total 8 cycles.
5. Decoder invalid=1, or opcode 11100 -> TRAP after DECODE, trap=1 held for 100 cycles, cleared only by rst.
6. MAX_WAIT=4 with mem_ready held low in FETCH -> TRAP after 4 wait cycles; a second run with mem_ready=1 on the 4th cycle -> DECODE, no trap.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared encodings for the RV32I multi-cycle sequencer.
//   state_t   : sequencer state encoding (also exported on ctrl_fsm.o_state)
//   OPC_*     : insn[6:2] major-opcode constants
//   pc_sel_t  : PC next-value mux encoding
//   wb_sel_t  : register-file write-back mux encoding
// Shared with the decoder and datapath so all three agree on encodings.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  // Encoding 3 is unused.
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_TARGET = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_IMM = 2'd3
  } wb_sel_t;

  // Opcodes this core executes; everything else (SYSTEM included) traps.
  function automatic logic is_legal_opcode(input logic [4:0] opc);
    case (opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE,
      OPC_OP, OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// ctrl_wait_cnt -- memory-handshake timeout counter.
//   clk, rst     : clock, asynchronous active-high reset
//   i_req        : a memory request is outstanding this cycle
//   i_ready      : memory completes the request this cycle
//   o_timeout    : this is the MAX_WAIT-th consecutive unanswered cycle
// The count restarts whenever no request is outstanding or the memory
// answers, so each request starts from zero. MAX_WAIT = 0 disables the
// timeout. MAX_WAIT must be < 2**WAIT_W.
module ctrl_wait_cnt #(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ready,
  output logic o_timeout
);

  logic [WAIT_W-1:0] r_cnt;
  logic              w_waiting;

  assign w_waiting = i_req & ~i_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_cnt <= '0;
    else if (w_waiting) r_cnt <= r_cnt + WAIT_W'(1);
    else                r_cnt <= '0;
  end

  // Fire on the cycle whose miss would make the count reach MAX_WAIT, so the
  // FSM enters TRAP right after MAX_WAIT unanswered cycles; a ready in that
  // same cycle clears w_waiting and therefore wins.
  generate
    if (MAX_WAIT == 0) begin : g_no_limit
      assign o_timeout = 1'b0;
    end else begin : g_limit
      localparam logic [WAIT_W-1:0] LP_LAST = WAIT_W'(MAX_WAIT - 1);
      assign o_timeout = w_waiting && (r_cnt == LP_LAST);
    end
  endgenerate

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm -- multi-cycle sequencer for the RV32I core.
//   clk, rst       : clock, asynchronous active-high reset
//   i_opcode       : insn[6:2] (IR-registered, stable from DECODE on)
//   i_invalid      : decoder invalid flag
//   i_br_taken     : branch compare result, used in EXEC
//   i_mem_ready    : memory completes the current request
//   o_mem_req/o_mem_we/o_addr_sel : shared memory port control
//   o_ir_we, o_pc_we, o_pc_sel    : IR and PC update
//   o_alu_a_sel, o_alu_b_sel      : ALU operand muxes
//   o_rf_we, o_wb_sel             : register-file write-back
//   o_trap         : sticky fault flag, cleared only by rst
//   o_state        : current state (debug)
//   o_instret      : retired-instruction count (only with CTRL_INSTRET_EN)
// Optional feature macro: CTRL_INSTRET_EN.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] i_opcode,
  input  logic       i_invalid,
  input  logic       i_br_taken,
  input  logic       i_mem_ready,
  output logic       o_mem_req,
  output logic       o_mem_we,
  output logic       o_addr_sel,
  output logic       o_ir_we,
  output logic       o_pc_we,
  output logic [1:0] o_pc_sel,
  output logic       o_alu_a_sel,
  output logic       o_alu_b_sel,
  output logic       o_rf_we,
  output logic [1:0] o_wb_sel,
  output logic       o_trap,
  output logic [2:0] o_state
`ifdef CTRL_INSTRET_EN
  ,
  output logic [63:0] o_instret
`endif
);

  state_t r_state;
  state_t w_next;
  logic   w_mem_phase;
  logic   w_timeout;
  logic   w_alu_a;
  logic   w_alu_b;

  assign w_mem_phase = (r_state == ST_FETCH) || (r_state == ST_MEM);

  // Operand selects follow the opcode and are held from EXEC through WB so
  // the ALU result stays valid for the address phase and write-back.
  assign w_alu_a = (i_opcode == OPC_AUIPC) || (i_opcode == OPC_JAL);
  assign w_alu_b = w_alu_a || (i_opcode == OPC_OP_IMM) || (i_opcode == OPC_LOAD) ||
                   (i_opcode == OPC_STORE) || (i_opcode == OPC_JALR);

  // Driven from the registered state rather than o_mem_req so the timeout
  // does not loop back through the output decoder.
  ctrl_wait_cnt #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_mem_phase),
    .i_ready   (i_mem_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output and w_next is defaulted first, so no branch below can
    // leave a value unassigned and infer a latch.
    w_next      = r_state;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_addr_sel  = 1'b0;
    o_ir_we     = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = PC_PLUS4;
    o_alu_a_sel = 1'b0;
    o_alu_b_sel = 1'b0;
    o_rf_we     = 1'b0;
    o_wb_sel    = WB_ALU;
    o_trap      = 1'b0;

    case (r_state)
      ST_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_we = 1'b1;
          w_next  = ST_DECODE;
        end else if (w_timeout) begin
          w_next = ST_TRAP;
        end
      end

      ST_DECODE: begin
        w_next = (i_invalid || !is_legal_opcode(i_opcode)) ? ST_TRAP : ST_EXEC;
      end

      ST_EXEC: begin
        o_alu_a_sel = w_alu_a;
        o_alu_b_sel = w_alu_b;
        case (i_opcode)
          OPC_LOAD, OPC_STORE: w_next = ST_MEM;
          OPC_BRANCH: begin
            o_pc_we  = 1'b1;
            o_pc_sel = i_br_taken ? PC_TARGET : PC_PLUS4;
            w_next   = ST_FETCH;
          end
          OPC_MISC_MEM: begin
            o_pc_we = 1'b1;
            w_next  = ST_FETCH;
          end
          default: w_next = ST_WB;
        endcase
      end

      ST_MEM: begin
        o_alu_a_sel = w_alu_a;
        o_alu_b_sel = w_alu_b;
        o_mem_req   = 1'b1;
        o_addr_sel  = 1'b1;
        o_mem_we    = (i_opcode == OPC_STORE);
        if (i_mem_ready) begin
          if (i_opcode == OPC_STORE) begin
            o_pc_we = 1'b1;
            w_next  = ST_FETCH;
          end else begin
            w_next = ST_WB;
          end
        end else if (w_timeout) begin
          w_next = ST_TRAP;
        end
      end

      ST_WB: begin
        o_alu_a_sel = w_alu_a;
        o_alu_b_sel = w_alu_b;
        o_rf_we     = 1'b1;
        o_pc_we     = 1'b1;
        case (i_opcode)
          OPC_LOAD:           o_wb_sel = WB_MEM;
          OPC_JAL, OPC_JALR:  o_wb_sel = WB_PC4;
          OPC_LUI:            o_wb_sel = WB_IMM;
          default:            o_wb_sel = WB_ALU;
        endcase
        case (i_opcode)
          OPC_JAL:  o_pc_sel = PC_TARGET;
          OPC_JALR: o_pc_sel = PC_JALR;
          default:  o_pc_sel = PC_PLUS4;
        endcase
        w_next = ST_FETCH;
      end

      ST_TRAP: o_trap = 1'b1;

      default: w_next = ST_TRAP;
    endcase

    // While reset is held the datapath must see no request and no update,
    // even though the state register already reads FETCH.
    if (rst) begin
      o_mem_req   = 1'b0;
      o_mem_we    = 1'b0;
      o_addr_sel  = 1'b0;
      o_ir_we     = 1'b0;
      o_pc_we     = 1'b0;
      o_pc_sel    = PC_PLUS4;
      o_alu_a_sel = 1'b0;
      o_alu_b_sel = 1'b0;
      o_rf_we     = 1'b0;
      o_wb_sel    = WB_ALU;
      o_trap      = 1'b0;
    end
  end

  assign o_state = r_state;

`ifdef CTRL_INSTRET_EN
  logic [63:0] r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_instret <= '0;
    else if (o_pc_we) r_instret <= r_instret + 64'd1;
  end

  assign o_instret = r_instret;
`endif

endmodule

// File: tb/tb_ctrl_fsm.sv
// tb_ctrl_fsm -- self-checking bench for ctrl_fsm. Two instances share all
// inputs: dut (MAX_WAIT=0, wait forever) and dut_to (MAX_WAIT=4). The
// expected trace of each instruction is derived from its cycle schedule
// (fetch waits, fixed phase lengths, memory waits).
module tb_ctrl_fsm;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam int         TO_WAIT    = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic       invalid, br_taken, mem_ready;

  logic       mem_req, mem_we, addr_sel, ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we, trap;
  logic [1:0] pc_sel, wb_sel;
  logic [2:0] state;
  logic       t_mem_req, t_mem_we, t_addr_sel, t_ir_we, t_pc_we, t_alu_a_sel, t_alu_b_sel;
  logic       t_rf_we, t_trap;
  logic [1:0] t_pc_sel, t_wb_sel;
  logic [2:0] t_state;
`ifdef CTRL_INSTRET_EN
  logic [63:0] instret, t_instret;
`endif

  logic [15:0] obs, t_obs;
  int          n_checks = 0;
  int          n_errors = 0;
  longint unsigned retired = 0;

  assign obs   = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                  rf_we, wb_sel, trap, state};
  assign t_obs = {t_mem_req, t_mem_we, t_addr_sel, t_ir_we, t_pc_we, t_pc_sel, t_alu_a_sel,
                  t_alu_b_sel, t_rf_we, t_wb_sel, t_trap, t_state};

  always #5 clk = ~clk;

  ctrl_fsm #(.MAX_WAIT(0), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst), .i_opcode(opcode), .i_invalid(invalid), .i_br_taken(br_taken),
    .i_mem_ready(mem_ready), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_addr_sel(addr_sel),
    .o_ir_we(ir_we), .o_pc_we(pc_we), .o_pc_sel(pc_sel), .o_alu_a_sel(alu_a_sel),
    .o_alu_b_sel(alu_b_sel), .o_rf_we(rf_we), .o_wb_sel(wb_sel), .o_trap(trap),
    .o_state(state)
`ifdef CTRL_INSTRET_EN
    , .o_instret(instret)
`endif
  );

  ctrl_fsm #(.MAX_WAIT(TO_WAIT), .WAIT_W(8)) dut_to (
    .clk(clk), .rst(rst), .i_opcode(opcode), .i_invalid(invalid), .i_br_taken(br_taken),
    .i_mem_ready(mem_ready), .o_mem_req(t_mem_req), .o_mem_we(t_mem_we),
    .o_addr_sel(t_addr_sel), .o_ir_we(t_ir_we), .o_pc_we(t_pc_we), .o_pc_sel(t_pc_sel),
    .o_alu_a_sel(t_alu_a_sel), .o_alu_b_sel(t_alu_b_sel), .o_rf_we(t_rf_we),
    .o_wb_sel(t_wb_sel), .o_trap(t_trap), .o_state(t_state)
`ifdef CTRL_INSTRET_EN
    , .o_instret(t_instret)
`endif
  );

  function automatic logic [15:0] pack(input logic req, we, asel, irwe, pcwe,
                                       input logic [1:0] pcs, input logic aa, ab, rfwe,
                                       input logic [1:0] wbs, input logic tr,
                                       input logic [2:0] st);
    return {req, we, asel, irwe, pcwe, pcs, aa, ab, rfwe, wbs, tr, st};
  endfunction

  // Asserts rst mid-cycle (no clock edge), checks both instances clear at
  // once, and releases just after a rising edge so the next cycle is FETCH #1.
  task automatic do_reset(input string name);
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 16'h0 || t_obs !== 16'h0) begin
      n_errors++;
      $display("FAIL %s async reset: got %h/%h, expected 0000", name, obs, t_obs);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 16'h0 || t_obs !== 16'h0) begin
      n_errors++;
      $display("FAIL %s held reset: got %h/%h, expected 0000", name, obs, t_obs);
    end
`ifdef CTRL_INSTRET_EN
    n_checks++;
    if (instret !== 64'd0) begin
      n_errors++;
      $display("FAIL %s instret in reset: got %0d, expected 0", name, instret);
    end
`endif
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_ready = 1'b0;
    retired   = 0;
  endtask

  // One instruction: fw fetch-wait cycles, mw memory-wait cycles.
  task automatic run_insn(input logic [4:0] op, input logic br, input int fw, input int mw,
                          input string name);
    logic        is_mem, is_store, aa, ab, alu_spec, pcwe, rfwe;
    logic [1:0]  wbs, pcs;
    logic [15:0] exp, mask;
    int          mend, total;
    is_store = (op == OPC_STORE);
    is_mem   = is_store || (op == OPC_LOAD);
    mend     = fw + 4 + mw;
    total    = fw + ((op == OPC_LOAD) ? 5 : (op == OPC_BRANCH || op == OPC_MISC) ? 3 : 4)
               + (is_mem ? mw : 0);
    wbs = (op == OPC_LOAD) ? 2'd1 : (op == OPC_JAL || op == OPC_JALR) ? 2'd2 :
          (op == OPC_LUI) ? 2'd3 : 2'd0;
    pcs = (op == OPC_JAL) ? 2'd1 : (op == OPC_JALR) ? 2'd2 : 2'd0;
    aa  = (op == OPC_AUIPC) || (op == OPC_JAL);
    ab  = aa || (op == OPC_OP_IMM) || (op == OPC_LOAD) || is_store || (op == OPC_JALR);
    alu_spec = !((op == OPC_LUI) || (op == OPC_MISC) || (op == OPC_BRANCH));
    opcode   = op;
    invalid  = 1'b0;
    br_taken = br;
    for (int c = 1; c <= total; c++) begin
      pcwe = 1'b0;
      rfwe = 1'b0;
      if (c <= fw + 1) begin
        mem_ready = (c == fw + 1);
        exp = pack(1'b1, 1'b0, 1'b0, (c == fw + 1), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
      end else if (c == fw + 2) begin
        mem_ready = 1'($urandom_range(0, 1));
        exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1);
      end else if (c == fw + 3) begin
        mem_ready = 1'($urandom_range(0, 1));
        pcwe = (c == total);
        exp = pack(1'b0, 1'b0, 1'b0, 1'b0, pcwe, (op == OPC_BRANCH && br) ? 2'd1 : 2'd0,
                   aa, ab, 1'b0, 2'd0, 1'b0, 3'd2);
      end else if (is_mem && c <= mend) begin
        mem_ready = (c == mend);
        pcwe = is_store && (c == total);
        exp = pack(1'b1, is_store, 1'b1, 1'b0, pcwe, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        pcwe = 1'b1;
        rfwe = 1'b1;
        exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, pcs, 1'b0, 1'b0, 1'b1, wbs, 1'b0, 3'd4);
      end
      mask = 16'hFFFF;
      if (!(c == fw + 3 && alu_spec)) mask[8:7] = 2'b00;
      if (!pcwe) mask[10:9] = 2'b00;
      if (!rfwe) mask[5:4] = 2'b00;
      @(negedge clk);
      n_checks++;
      if ((obs & mask) !== (exp & mask)) begin
        n_errors++;
        $display("FAIL %s op=%b cycle %0d: got %h, expected %h (mask %h)",
                 name, op, c, obs, exp, mask);
      end
      @(posedge clk);
      #1;
    end
    retired++;
  endtask

  // Fetch, decode, then 100 cycles of sticky TRAP under random inputs.
  task automatic run_trap(input logic [4:0] op, input logic inv, input int fw,
                          input string name);
    logic [15:0] exp;
    logic [15:0] mask;
    mask     = 16'hFFFF;
    mask[10:9] = 2'b00;
    mask[8:7]  = 2'b00;
    mask[5:4]  = 2'b00;
    opcode   = op;
    invalid  = inv;
    br_taken = 1'b0;
    for (int c = 1; c <= fw + 102; c++) begin
      if (c <= fw + 1) begin
        mem_ready = (c == fw + 1);
        exp = pack(1'b1, 1'b0, 1'b0, (c == fw + 1), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
      end else if (c == fw + 2) begin
        mem_ready = 1'($urandom_range(0, 1));
        exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd1);
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        opcode    = 5'($urandom);
        invalid   = 1'($urandom_range(0, 1));
        exp = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd5);
      end
      @(negedge clk);
      n_checks++;
      if ((obs & mask) !== (exp & mask)) begin
        n_errors++;
        $display("FAIL %s cycle %0d: got %h, expected %h", name, c, obs, exp);
      end
      @(posedge clk);
      #1;
    end
    #2;
    do_reset({name, "_clear"});
    invalid = 1'b0;
  endtask

  task automatic test_reset;
    opcode = OPC_LOAD; invalid = 1'b0; br_taken = 1'b0;
    do_reset("reset_init");
    // Mid-FETCH: request must be up from the first cycle after release.
    for (int c = 1; c <= 3; c++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || state !== 3'd0) begin
        n_errors++;
        $display("FAIL reset_fetch cycle %0d: mem_req=%b state=%0d, expected 1/0", c, mem_req, state);
      end
      @(posedge clk);
      #1;
    end
    #2;
    do_reset("reset_mid_fetch");
    // Mid-MEM of a LOAD: reset must abandon the request immediately.
    for (int c = 1; c <= 6; c++) begin
      mem_ready = (c == 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_checks++;
    if (state !== 3'd3 || mem_req !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_pre_mem: state=%0d mem_req=%b, expected 3/1", state, mem_req);
    end
    #1;
    do_reset("reset_mid_mem");
    run_insn(OPC_OP, 1'b0, 0, 0, "reset_recover");
  endtask

  task automatic test_op;
    run_insn(OPC_OP, 1'b0, 0, 0, "op");
    run_insn(OPC_OP_IMM, 1'b0, 2, 0, "op_imm");
    run_insn(OPC_LUI, 1'b0, 0, 0, "lui");
    run_insn(OPC_AUIPC, 1'b0, 1, 0, "auipc");
    run_insn(OPC_JAL, 1'b0, 0, 0, "jal");
    run_insn(OPC_JALR, 1'b0, 3, 0, "jalr");
  endtask

  task automatic test_branch;
    run_insn(OPC_BRANCH, 1'b1, 0, 0, "branch_taken");
    run_insn(OPC_BRANCH, 1'b0, 0, 0, "branch_not_taken");
    run_insn(OPC_MISC, 1'b1, 0, 0, "fence");
  endtask

  task automatic test_mem;
    run_insn(OPC_LOAD, 1'b0, 0, 3, "load_wait3");
    run_insn(OPC_LOAD, 1'b0, 0, 0, "load_nowait");
    run_insn(OPC_STORE, 1'b0, 0, 0, "store_nowait");
    run_insn(OPC_STORE, 1'b0, 1, 2, "store_wait2");
  endtask

  task automatic test_trap;
    run_trap(OPC_OP, 1'b1, 0, "trap_invalid");
    run_trap(OPC_SYSTEM, 1'b0, 1, "trap_system");
    run_trap(5'b00001, 1'b0, 0, "trap_illegal");
  endtask

  task automatic test_timeout;
    logic [2:0] exp_st;
    do_reset("timeout_pre");
    opcode = OPC_LOAD; invalid = 1'b0; br_taken = 1'b0;
    // Fetch never answered: dut_to traps after TO_WAIT cycles, dut waits on.
    for (int c = 1; c <= 24; c++) begin
      mem_ready = 1'b0;
      exp_st = (c <= TO_WAIT) ? 3'd0 : 3'd5;
      @(negedge clk);
      n_checks++;
      if (t_state !== exp_st || t_trap !== (c > TO_WAIT)) begin
        n_errors++;
        $display("FAIL timeout_fetch cycle %0d: state=%0d trap=%b, expected %0d/%b",
                 c, t_state, t_trap, exp_st, (c > TO_WAIT));
      end
      n_checks++;
      if (state !== 3'd0 || trap !== 1'b0 || mem_req !== 1'b1) begin
        n_errors++;
        $display("FAIL wait_forever cycle %0d: state=%0d trap=%b req=%b, expected 0/0/1",
                 c, state, trap, mem_req);
      end
      @(posedge clk);
      #1;
    end
    do_reset("timeout_mid");
    // Ready on the last allowed cycle wins; then a LOAD whose MEM phase
    // is never answered must time out.
    for (int c = 1; c <= 12; c++) begin
      mem_ready = (c == TO_WAIT);
      if (c <= TO_WAIT)               exp_st = 3'd0;
      else if (c == TO_WAIT + 1)      exp_st = 3'd1;
      else if (c == TO_WAIT + 2)      exp_st = 3'd2;
      else if (c <= 2 * TO_WAIT + 2)  exp_st = 3'd3;
      else                            exp_st = 3'd5;
      @(negedge clk);
      n_checks++;
      if (t_state !== exp_st || t_trap !== (exp_st == 3'd5)) begin
        n_errors++;
        $display("FAIL timeout_edge cycle %0d: state=%0d trap=%b, expected %0d",
                 c, t_state, t_trap, exp_st);
      end
      @(posedge clk);
      #1;
    end
    #2;
    do_reset("timeout_post");
  endtask

  task automatic test_back_to_back;
    logic [4:0] legal [10];
    legal = '{OPC_LOAD, OPC_MISC, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP, OPC_LUI,
              OPC_BRANCH, OPC_JALR, OPC_JAL};
    for (int i = 0; i < 60; i++) begin
      run_insn(legal[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), "random");
    end
    n_checks++;
    if (t_trap !== 1'b0) begin
      n_errors++;
      $display("FAIL random_no_timeout: trap=%b, expected 0", t_trap);
    end
`ifdef CTRL_INSTRET_EN
    n_checks++;
    if (instret !== retired) begin
      n_errors++;
      $display("FAIL instret: got %0d, expected %0d", instret, retired);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; opcode = 5'd0; invalid = 1'b0; br_taken = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    test_op;
    test_branch;
    test_mem;
    test_trap;
    test_timeout;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
